cond_logic: RTL
===============

// Module: cond_logic
// PURPOSE
//  Conditional-execution stage between the instruction decoder and DataPath.
//  Holds the architectural NZCV flag register and evaluates instr[31:28] against it.
//  Gates the decoder's raw write/branch strobes into the pc_src, reg_write and
//  mem_write controls.
//  Supplies the registered carry to DataPath for shifter and ADC/SBC use.
// PARAMETERS
//  RESET_FLAGS  4'b0000  NZCV value loaded on reset, bit order {N,Z,C,V}
// PORTS
//  clk          in   1  system clock; all state updates on posedge
//  reset        in   1  synchronous, active-high; clears flag register to RESET_FLAGS
//  cond         in   4  instr[31:28] condition field
//  alu_flags    in   4  {N,Z,C,V} from the current-cycle ALU result
//  flag_write   in   2  [1]=update N,Z  [0]=update C,V (from decoder; S-bit / CMP)
//  pc_s         in   1  raw branch / PC-write request from decoder
//  reg_w        in   1  raw register-file write request
//  mem_w        in   1  raw data-memory write request
//  no_write     in   1  compare-class op (CMP/CMN/TST/TEQ): suppress reg write
//  pc_src       out  1  gated pc_s
//  reg_write    out  1  gated reg_w
//  mem_write    out  1  gated mem_w
//  carry        out  1  registered C flag (flags_q[1]) to DataPath
//  flags        out  4  registered NZCV, for debug and bench visibility
// BEHAVIOUR
//  - Flag register flags_q[3:0]. Reset (sync): flags_q <= RESET_FLAGS.
//    All combinational outputs then follow flags_q.
//  - cond_ex is combinational from cond and flags_q, never from alu_flags:
//    EQ Z | NE !Z | CS C | CC !C | MI N | PL !N | VS V | VC !V | HI C&!Z
//    LS !C|Z | GE N==V | LT N!=V | GT !Z&(N==V) | LE Z|(N!=V) | AL 1 | 4'b1111 -> 0
//  - pc_src = pc_s & cond_ex; mem_write = mem_w & cond_ex.
//  - reg_write = reg_w & cond_ex & !no_write.
//  - Update at posedge when !reset & cond_ex:
//    flag_write[1] -> flags_q[3:2] <= alu_flags[3:2].
//    flag_write[0] -> flags_q[1:0] <= alu_flags[1:0].
//    The two halves are independent; an un-enabled half holds its value.
//  - Latency: the flag update is visible on flags/carry one cycle after the
//    setting instruction. The same-cycle instruction is evaluated on old flags.
//  - Condition fails: no flag update, even if flag_write != 0. All gated
//    outputs are 0.
//  - reset and flag_write high in the same edge: reset wins.
//  - Mid-operation reset: the next cycle evaluates against RESET_FLAGS
//    (EQ fails, NE passes when RESET_FLAGS = 0).
//  - No X propagation: any X on cond is out of contract. Outputs are
//    defined for all 16 encodings.
// STRUCTURE
//  - cpu_pkg holds:
//    - typedef enum logic [3:0] cond_e {EQ..AL,NV}
//    - localparam flag indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
//    - typedef logic [3:0] nzcv_t
//  - Sub-module cond_check: purely combinational (cond, nzcv) -> cond_ex.
//    It is reused by any later pipelined variant.
//  - cond_logic contains the flag register, the update enables and the
//    output gating.
// TESTING
//  1. reset=1 one edge; flags=0000, carry=0. cond=EQ, reg_w=1: reg_write=0.
//     cond=NE, reg_w=1: reg_write=1.
//  2. CMP (cond=AL, no_write=1, flag_write=11, alu_flags=0110) -> reg_write=0
//     that cycle. Next cycle flags=0110, carry=1; cond=EQ, pc_s=1 -> pc_src=1.
//  3. Partial update: flags=0110, flag_write=10, alu_flags=1001
//     -> next cycle flags=1010 (C,V held).
//  4. Failed condition: flags=0000, cond=EQ, flag_write=11, alu_flags=1111,
//     mem_w=1 -> mem_write=0. Next cycle flags still 0000.
//  5. Signed compares: flags=1000 -> LT=1, GE=0. flags=1001 -> GE=1, GT=1.
//     flags=0100 -> LE=1, GT=0, HI=0. cond=1111 -> all gated outputs 0.
//  6. Simultaneous: flags=0110, reset=1 with flag_write=11, alu_flags=1111
//     -> next cycle flags=RESET_FLAGS. Sweep all 16 cond x 16 flag values
//     against a reference model.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared types and constants for the conditional-execution stage.
//   - cond_e  : the sixteen encodings of the instr[31:28] condition field
//   - nzcv_t  : the 4-bit architectural flag word, bit order {N,Z,C,V}
//   - FLAG_*  : bit positions of each flag inside nzcv_t
//   - flags_signed_ge : N==V, the "signed greater-or-equal" term that
//     GE/LT/GT/LE all build on
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,  // Z set
    NE = 4'b0001,  // Z clear
    CS = 4'b0010,  // C set
    CC = 4'b0011,  // C clear
    MI = 4'b0100,  // N set
    PL = 4'b0101,  // N clear
    VS = 4'b0110,  // V set
    VC = 4'b0111,  // V clear
    HI = 4'b1000,  // unsigned higher
    LS = 4'b1001,  // unsigned lower or same
    GE = 4'b1010,  // signed greater or equal
    LT = 4'b1011,  // signed less than
    GT = 4'b1100,  // signed greater than
    LE = 4'b1101,  // signed less or equal
    AL = 4'b1110,  // always
    NV = 4'b1111   // never (reserved encoding, treated as never-execute)
  } cond_e;

  typedef logic [3:0] nzcv_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Signed comparison result after a SUBS/CMP: a>=b exactly when the sign
  // bit agrees with the overflow bit.
  function automatic logic flags_signed_ge(input nzcv_t f);
    return (f[FLAG_N] == f[FLAG_V]);
  endfunction

endpackage : cpu_pkg

// File: rtl/cond_check.sv
// -----------------------------------------------------------------------------
// cond_check
//   Purely combinational condition evaluator. Decides whether an instruction
//   with condition field `cond` executes given the flag word `nzcv`.
//   Kept stateless so a pipelined stage can instantiate it against whichever
//   flag copy it needs (architectural, forwarded, ...).
//
// Ports
//   cond     in  4  instr[31:28] condition field
//   nzcv     in  4  flag word {N,Z,C,V} to evaluate against
//   cond_ex  out 1  1 = instruction executes
// -----------------------------------------------------------------------------
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_ex
);

  logic n_flag;
  logic z_flag;
  logic c_flag;
  logic v_flag;
  logic sge;

  assign n_flag = nzcv[FLAG_N];
  assign z_flag = nzcv[FLAG_Z];
  assign c_flag = nzcv[FLAG_C];
  assign v_flag = nzcv[FLAG_V];
  assign sge    = flags_signed_ge(nzcv);

  always_comb begin
    // NOTE: a default assignment at the top of every always_comb guarantees
    // every path drives the output, so no latch can be inferred even if a
    // case arm is later removed.
    cond_ex = 1'b0;
    unique case (cond_e'(cond))
      EQ: cond_ex =  z_flag;
      NE: cond_ex = ~z_flag;
      CS: cond_ex =  c_flag;
      CC: cond_ex = ~c_flag;
      MI: cond_ex =  n_flag;
      PL: cond_ex = ~n_flag;
      VS: cond_ex =  v_flag;
      VC: cond_ex = ~v_flag;
      HI: cond_ex =  c_flag & ~z_flag;
      LS: cond_ex = ~c_flag |  z_flag;
      GE: cond_ex =  sge;
      LT: cond_ex = ~sge;
      GT: cond_ex = ~z_flag & sge;
      LE: cond_ex =  z_flag | ~sge;
      AL: cond_ex = 1'b1;
      NV: cond_ex = 1'b0;  // reserved encoding never executes
      default: cond_ex = 1'b0;
    endcase
  end

endmodule : cond_check

// File: rtl/cond_logic.sv
// -----------------------------------------------------------------------------
// cond_logic
//   Conditional-execution stage between the instruction decoder and DataPath.
//   Holds the architectural NZCV register, evaluates the instruction's
//   condition against it and gates the decoder's raw strobes. The carry flag
//   is exported registered for shifter and ADC/SBC use.
//
// Parameters
//   RESET_FLAGS  NZCV value loaded on reset, bit order {N,Z,C,V}
//
// Ports
//   clk          in   1  system clock, all state updates on posedge
//   reset        in   1  synchronous active-high reset
//   cond         in   4  instr[31:28] condition field
//   alu_flags    in   4  {N,Z,C,V} produced by this cycle's ALU result
//   flag_write   in   2  [1] update N,Z   [0] update C,V
//   pc_s         in   1  raw branch / PC-write request
//   reg_w        in   1  raw register-file write request
//   mem_w        in   1  raw data-memory write request
//   no_write     in   1  compare-class op, never writes the register file
//   pc_src       out  1  gated pc_s
//   reg_write    out  1  gated reg_w
//   mem_write    out  1  gated mem_w
//   carry        out  1  registered C flag
//   flags        out  4  registered NZCV
// -----------------------------------------------------------------------------
module cond_logic
  import cpu_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_write,
  input  logic       pc_s,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic       carry,
  output logic [3:0] flags
);

  nzcv_t flags_q;
  nzcv_t flags_d;
  logic  cond_ex;
  logic  upd_nz;
  logic  upd_cv;

  // The condition is always judged on the committed flags, never on this
  // cycle's ALU output: an instruction cannot predicate on its own result.
  cond_check u_cond_check (
    .cond    (cond),
    .nzcv    (flags_q),
    .cond_ex (cond_ex)
  );

  // A failing instruction is squashed entirely, including its flag update.
  assign upd_nz = cond_ex & flag_write[1];
  assign upd_cv = cond_ex & flag_write[0];

  always_comb begin
    flags_d = flags_q;
    if (upd_nz) begin
      flags_d[FLAG_N] = alu_flags[FLAG_N];
      flags_d[FLAG_Z] = alu_flags[FLAG_Z];
    end
    if (upd_cv) begin
      flags_d[FLAG_C] = alu_flags[FLAG_C];
      flags_d[FLAG_V] = alu_flags[FLAG_V];
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering in simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= RESET_FLAGS;  // reset overrides any same-edge flag write
    end else begin
      flags_q <= flags_d;
    end
  end

  assign pc_src    = pc_s  & cond_ex;
  assign mem_write = mem_w & cond_ex;
  assign reg_write = reg_w & cond_ex & ~no_write;

  assign carry = flags_q[FLAG_C];
  assign flags = flags_q;

endmodule : cond_logic
